// File: rtl/filt_intp_pkg.sv
// Shared constants, coefficient table and FSM encoding for the polyphase interpolating FIR.
// The coefficient table is generated; regenerate rather than hand-edit.
package filt_intp_pkg;

    localparam int gp_data_width   = 8;
    localparam int gp_coeff_width  = 12;
    localparam int gp_intp_factor  = 4;
    localparam int gp_phase_length = 4;

    localparam int gp_num_coeff    = gp_intp_factor * gp_phase_length;
    localparam int gp_prod_width   = gp_data_width + gp_coeff_width;
    localparam int gp_oup_width    = gp_prod_width + $clog2(gp_phase_length);
    localparam int gp_acc_width    = gp_oup_width;
    localparam int gp_p_cnt_width  = $clog2(gp_intp_factor);
    localparam int gp_k_cnt_width  = $clog2(gp_phase_length);
    localparam int gp_idx_width    = $clog2(gp_num_coeff);

    typedef logic signed [gp_coeff_width-1:0] coeff_t;

    localparam coeff_t gp_coeff [gp_num_coeff] = '{
        12'sd1,  12'sd2,  12'sd3,  12'sd4,
        12'sd5,  12'sd6,  12'sd7,  12'sd8,
        12'sd9,  12'sd10, 12'sd11, 12'sd12,
        12'sd13, 12'sd14, 12'sd15, 12'sd16
    };

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Tap k of branch p uses coefficient k*L + p.
    function automatic logic [gp_idx_width-1:0] coeff_index(
        input logic [gp_k_cnt_width-1:0] k,
        input logic [gp_p_cnt_width-1:0] p
    );
        return gp_idx_width'(int'(k) * gp_intp_factor + int'(p));
    endfunction

endpackage

// File: rtl/filt_intp_mac_if.sv
// Sample-in / sample-out bundle of the interpolating FIR.
// master drives samples in, slave is the filter.
interface filt_intp_mac_if;
    import filt_intp_pkg::*;

    logic signed [gp_data_width-1:0] i_data;
    logic                            i_valid;
    logic                            o_ready;
    logic signed [gp_oup_width-1:0]  o_data;
    logic                            o_valid;

    modport master (
        output i_data, i_valid,
        input  o_ready, o_data, o_valid
    );

    modport slave (
        input  i_data, i_valid,
        output o_ready, o_data, o_valid
    );

endinterface

// File: rtl/filt_intp_ctrl.sv
// Sequencer: walks tap k inside branch p, one MAC per enabled cycle.
//   state   | meaning
//   ST_IDLE | waiting for a sample, o_ready high
//   ST_RUN  | computing branches p=0..L-1, P taps each, o_ready low
module filt_intp_ctrl
    import filt_intp_pkg::*;
(
    input  logic                      i_clk,
    input  logic                      i_rst_an,
    input  logic                      i_ena,
    input  logic                      i_valid,
    output logic                      o_ready,
    output logic                      o_accept,
    output logic                      o_run,
    output logic                      o_last_tap,
    output logic [gp_idx_width-1:0]   o_coeff_idx,
    output logic [gp_k_cnt_width-1:0] o_tap_idx
);

    state_t                    state_q, state_d;
    logic [gp_p_cnt_width-1:0] p_q, p_d;
    logic [gp_k_cnt_width-1:0] k_q, k_d;

    always_ff @(posedge i_clk or negedge i_rst_an) begin
        if (!i_rst_an) begin
            state_q <= ST_IDLE;
            p_q     <= '0;
            k_q     <= '0;
        end else if (i_ena) begin
            state_q <= state_d;
            p_q     <= p_d;
            k_q     <= k_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        p_d        = p_q;
        k_d        = k_q;
        o_ready    = 1'b0;
        o_accept   = 1'b0;
        o_run      = 1'b0;
        o_last_tap = 1'b0;
        case (state_q)
            ST_IDLE: begin
                o_ready = 1'b1;
                if (i_valid) begin
                    o_accept = 1'b1;
                    state_d  = ST_RUN;
                    p_d      = '0;
                    k_d      = '0;
                end
            end
            ST_RUN: begin
                o_run = 1'b1;
                if (k_q == gp_k_cnt_width'(gp_phase_length - 1)) begin
                    o_last_tap = 1'b1;
                    k_d        = '0;
                    if (p_q == gp_p_cnt_width'(gp_intp_factor - 1)) begin
                        p_d     = '0;
                        state_d = ST_IDLE;
                    end else begin
                        p_d = p_q + gp_p_cnt_width'(1);
                    end
                end else begin
                    k_d = k_q + gp_k_cnt_width'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign o_coeff_idx = coeff_index(k_q, p_q);
    assign o_tap_idx   = k_q;

endmodule

// File: rtl/filt_intp_mac.sv
// Polyphase interpolating FIR on one shared MAC: each accepted sample yields L outputs.
// Holds the delay line, accumulator and registered output; sequencing lives in filt_intp_ctrl.
module filt_intp_mac
    import filt_intp_pkg::*;
(
    input  logic           i_clk,
    input  logic           i_rst_an,
    input  logic           i_ena,
    filt_intp_mac_if.slave bus
);

    logic                      accept, run, last_tap;
    logic [gp_idx_width-1:0]   coeff_idx;
    logic [gp_k_cnt_width-1:0] tap_idx;

    logic signed [gp_data_width-1:0] dl_q [gp_phase_length];
    logic signed [gp_data_width-1:0] dl_d [gp_phase_length];
    logic signed [gp_acc_width-1:0]  acc_q, acc_d;
    logic signed [gp_oup_width-1:0]  data_q, data_d;
    logic                            valid_q, valid_d;
    logic signed [gp_prod_width-1:0] prod;
    logic signed [gp_acc_width-1:0]  mac_sum;

    filt_intp_ctrl u_ctrl (
        .i_clk       (i_clk),
        .i_rst_an    (i_rst_an),
        .i_ena       (i_ena),
        .i_valid     (bus.i_valid),
        .o_ready     (bus.o_ready),
        .o_accept    (accept),
        .o_run       (run),
        .o_last_tap  (last_tap),
        .o_coeff_idx (coeff_idx),
        .o_tap_idx   (tap_idx)
    );

    // Operands widened first so the signed product is formed at full width.
    assign prod    = gp_prod_width'(dl_q[tap_idx]) * gp_prod_width'(gp_coeff[coeff_idx]);
    assign mac_sum = acc_q + gp_acc_width'(prod);

    always_comb begin
        dl_d    = dl_q;
        acc_d   = acc_q;
        data_d  = data_q;
        valid_d = 1'b0;
        if (accept) begin
            dl_d[0] = bus.i_data;
            for (int i = 1; i < gp_phase_length; i++) begin
                dl_d[i] = dl_q[i-1];
            end
        end
        if (run) begin
            if (last_tap) begin
                data_d  = mac_sum;
                valid_d = 1'b1;
                acc_d   = '0;
            end else begin
                acc_d = mac_sum;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_an) begin
        if (!i_rst_an) begin
            dl_q    <= '{default: '0};
            acc_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else if (i_ena) begin
            dl_q    <= dl_d;
            acc_q   <= acc_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign bus.o_data  = data_q;
    assign bus.o_valid = valid_q;

endmodule

// File: tb/tb_filt_intp_mac.sv
// Self-checking bench for filt_intp_mac: convolution reference model plus per-scenario tasks.
module tb_filt_intp_mac;
    import filt_intp_pkg::*;

    localparam int L  = 4;
    localparam int P  = 4;
    localparam int OW = gp_oup_width;

    logic i_clk = 1'b0;
    logic i_rst_an;
    logic i_ena;

    filt_intp_mac_if bus ();

    filt_intp_mac dut (
        .i_clk    (i_clk),
        .i_rst_an (i_rst_an),
        .i_ena    (i_ena),
        .bus      (bus)
    );

    always #5 i_clk = ~i_clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Reference model: history of accepted samples and position in the output burst.
    int hist[$];
    bit busy;
    int pos;
    bit exp_valid;
    int exp_data;

    int dut_outs[$];
    int dut_out_cyc[$];
    int dut_acc_cyc[$];

    function automatic int coef(int j);
        return j + 1;
    endfunction

    function automatic int model_y(int p);
        int s = 0;
        for (int k = 0; k < P; k++) s += hist[k] * coef(k * L + p);
        return s;
    endfunction

    function automatic void model_reset();
        hist.delete();
        for (int k = 0; k < P; k++) hist.push_back(0);
        busy      = 1'b0;
        pos       = 0;
        exp_valid = 1'b0;
        exp_data  = 0;
    endfunction

    function automatic void clear_logs();
        dut_outs.delete();
        dut_out_cyc.delete();
        dut_acc_cyc.delete();
    endfunction

    // Advance one clock: update the model from pre-edge inputs, record DUT accepts/strobes.
    task automatic step();
        bit en, m_acc, d_acc;
        int din;
        en    = i_ena;
        din   = int'(bus.i_data);
        m_acc = en && bus.i_valid && !busy;
        d_acc = en && bus.i_valid && bus.o_ready && i_rst_an;
        @(posedge i_clk);
        cyc++;
        if (d_acc) dut_acc_cyc.push_back(cyc);
        if (en && i_rst_an) begin
            exp_valid = 1'b0;
            if (busy) begin
                pos++;
                if (pos % P == 0) begin
                    exp_valid = 1'b1;
                    exp_data  = model_y(pos / P - 1);
                end
                if (pos == L * P) busy = 1'b0;
            end else if (m_acc) begin
                hist.push_front(din);
                void'(hist.pop_back());
                busy = 1'b1;
                pos  = 0;
            end
        end
        #1;
        if (en && bus.o_valid) begin
            dut_outs.push_back(int'(bus.o_data));
            dut_out_cyc.push_back(cyc);
        end
    endtask

    task automatic do_reset();
        i_rst_an     = 1'b0;
        bus.i_valid  = 1'b0;
        bus.i_data   = '0;
        i_ena        = 1'b1;
        model_reset();
        step();
        step();
        i_rst_an = 1'b1;
    endtask

    task automatic test_reset();
        i_rst_an    = 1'b0;
        i_ena       = 1'b1;
        bus.i_valid = 1'b0;
        bus.i_data  = '0;
        model_reset();
        repeat (3) step();
        checks++;
        if ({bus.o_ready, bus.o_valid, bus.o_data} !== {1'b1, 1'b0, {OW{1'b0}}}) begin
            errors++;
            $display("FAIL reset_hold rdy/vld/data got %b/%b/%0d want 1/0/0",
                     bus.o_ready, bus.o_valid, bus.o_data);
        end
        i_rst_an = 1'b1;
        repeat (5) begin
            step();
            checks++;
            if ({bus.o_ready, bus.o_valid, bus.o_data} !== {1'b1, 1'b0, {OW{1'b0}}}) begin
                errors++;
                $display("FAIL reset_release cyc=%0d rdy/vld/data got %b/%b/%0d want 1/0/0",
                         cyc, bus.o_ready, bus.o_valid, bus.o_data);
            end
        end
    endtask

    task automatic test_impulse(input string tag);
        int vals[4] = '{1, 0, 0, 0};
        int idx = 0;
        int n0;
        clear_logs();
        i_ena = 1'b1;
        repeat (4 * (L * P + 1) + 4) begin
            bus.i_valid = (idx < 4);
            bus.i_data  = gp_data_width'(vals[idx & 3]);
            n0 = dut_acc_cyc.size();
            step();
            if (dut_acc_cyc.size() != n0) idx++;
            checks++;
            if ({bus.o_ready, bus.o_valid, bus.o_data} !== {~busy, exp_valid, exp_data[OW-1:0]}) begin
                errors++;
                $display("FAIL %s cyc=%0d rdy/vld/data got %b/%b/%0d want %b/%b/%0d", tag, cyc,
                         bus.o_ready, bus.o_valid, bus.o_data, ~busy, exp_valid, exp_data);
            end
        end
        bus.i_valid = 1'b0;
        checks++;
        if (dut_outs.size() != 16) begin
            errors++;
            $display("FAIL %s_count strobes got %0d want 16", tag, dut_outs.size());
        end
        for (int i = 0; i < 16 && i < dut_outs.size(); i++) begin
            checks++;
            if (dut_outs[i] !== i + 1) begin
                errors++;
                $display("FAIL %s_value[%0d] got %0d want %0d", tag, i, dut_outs[i], i + 1);
            end
        end
        checks++;
        if (dut_acc_cyc.size() == 0 || dut_out_cyc.size() == 0 ||
            dut_out_cyc[0] - dut_acc_cyc[0] + 1 != P + 1) begin
            errors++;
            $display("FAIL %s_first_strobe cycle got %0d want %0d", tag,
                     (dut_acc_cyc.size() == 0 || dut_out_cyc.size() == 0) ? -1 :
                     dut_out_cyc[0] - dut_acc_cyc[0] + 1, P + 1);
        end
    endtask

    task automatic test_dc();
        int want[4] = '{-3584, -4096, -4608, -5120};
        int idx = 0;
        int n0;
        do_reset();
        clear_logs();
        repeat (5 * (L * P + 1) + 4) begin
            bus.i_valid = (idx < 5);
            bus.i_data  = -8'sd128;
            n0 = dut_acc_cyc.size();
            step();
            if (dut_acc_cyc.size() != n0) idx++;
            checks++;
            if ({bus.o_ready, bus.o_valid, bus.o_data} !== {~busy, exp_valid, exp_data[OW-1:0]}) begin
                errors++;
                $display("FAIL dc cyc=%0d rdy/vld/data got %b/%b/%0d want %b/%b/%0d", cyc,
                         bus.o_ready, bus.o_valid, bus.o_data, ~busy, exp_valid, exp_data);
            end
        end
        bus.i_valid = 1'b0;
        checks++;
        if (dut_outs.size() != 20) begin
            errors++;
            $display("FAIL dc_count strobes got %0d want 20", dut_outs.size());
        end else begin
            for (int p = 0; p < 4; p++) begin
                checks++;
                if (dut_outs[16 + p] !== want[p]) begin
                    errors++;
                    $display("FAIL dc_steady[%0d] got %0d want %0d", p, dut_outs[16 + p], want[p]);
                end
            end
        end
    endtask

    task automatic test_handshake();
        int idx = 0;
        int n0;
        do_reset();
        clear_logs();
        bus.i_data = gp_data_width'($urandom);
        repeat (3 * (L * P + 1) + 4) begin
            bus.i_valid = (idx < 3);
            n0 = dut_acc_cyc.size();
            step();
            if (dut_acc_cyc.size() != n0) begin
                idx++;
                bus.i_data = gp_data_width'($urandom);
            end
            checks++;
            if ({bus.o_ready, bus.o_valid, bus.o_data} !== {~busy, exp_valid, exp_data[OW-1:0]}) begin
                errors++;
                $display("FAIL handshake cyc=%0d rdy/vld/data got %b/%b/%0d want %b/%b/%0d", cyc,
                         bus.o_ready, bus.o_valid, bus.o_data, ~busy, exp_valid, exp_data);
            end
        end
        bus.i_valid = 1'b0;
        checks++;
        if (dut_acc_cyc.size() != 3) begin
            errors++;
            $display("FAIL handshake_accepts got %0d want 3", dut_acc_cyc.size());
        end else begin
            for (int i = 1; i < 3; i++) begin
                checks++;
                if (dut_acc_cyc[i] - dut_acc_cyc[i-1] != L * P + 1) begin
                    errors++;
                    $display("FAIL handshake_spacing[%0d] got %0d want %0d", i,
                             dut_acc_cyc[i] - dut_acc_cyc[i-1], L * P + 1);
                end
            end
        end
    endtask

    task automatic test_stall();
        int vals[4] = '{1, 0, 0, 0};
        int idx = 0;
        int n0, want_t;
        do_reset();
        clear_logs();
        repeat (4 * (L * P + 1) + 8) begin
            bus.i_valid = (idx < 4);
            bus.i_data  = gp_data_width'(vals[idx & 3]);
            i_ena = !(dut_acc_cyc.size() > 0 && (cyc - dut_acc_cyc[0]) inside {[6:8]});
            n0 = dut_acc_cyc.size();
            step();
            if (dut_acc_cyc.size() != n0) idx++;
            checks++;
            if ({bus.o_ready, bus.o_valid, bus.o_data} !== {~busy, exp_valid, exp_data[OW-1:0]}) begin
                errors++;
                $display("FAIL stall cyc=%0d rdy/vld/data got %b/%b/%0d want %b/%b/%0d", cyc,
                         bus.o_ready, bus.o_valid, bus.o_data, ~busy, exp_valid, exp_data);
            end
        end
        i_ena       = 1'b1;
        bus.i_valid = 1'b0;
        checks++;
        if (dut_outs.size() != 16 || dut_acc_cyc.size() == 0) begin
            errors++;
            $display("FAIL stall_count strobes got %0d want 16", dut_outs.size());
        end else begin
            for (int i = 0; i < 16; i++) begin
                want_t = 17 * (i / 4) + 4 * (i % 4 + 1) + ((i >= 1) ? 3 : 0);
                checks++;
                if (dut_outs[i] !== i + 1 || dut_out_cyc[i] - dut_acc_cyc[0] != want_t) begin
                    errors++;
                    $display("FAIL stall_strobe[%0d] value/offset got %0d/%0d want %0d/%0d", i,
                             dut_outs[i], dut_out_cyc[i] - dut_acc_cyc[0], i + 1, want_t);
                end
            end
        end
    endtask

    task automatic test_reset_mid_run();
        int budget = 40;
        do_reset();
        clear_logs();
        bus.i_valid = 1'b1;
        bus.i_data  = 8'sd1;
        while (budget > 0 && !(dut_acc_cyc.size() > 0 && cyc - dut_acc_cyc[0] == 9)) begin
            if (dut_acc_cyc.size() > 0) bus.i_data = '0;
            step();
            budget--;
            checks++;
            if ({bus.o_ready, bus.o_valid, bus.o_data} !== {~busy, exp_valid, exp_data[OW-1:0]}) begin
                errors++;
                $display("FAIL rst_run cyc=%0d rdy/vld/data got %b/%b/%0d want %b/%b/%0d", cyc,
                         bus.o_ready, bus.o_valid, bus.o_data, ~busy, exp_valid, exp_data);
            end
        end
        checks++;
        if (budget == 0) begin
            errors++;
            $display("FAIL rst_run_timeout reached phase 2 got no want yes");
        end
        checks++;
        if (dut_outs.size() != 2) begin
            errors++;
            $display("FAIL rst_run_pre strobes got %0d want 2", dut_outs.size());
        end
        bus.i_valid = 1'b0;
        #2;
        i_rst_an = 1'b0;
        model_reset();
        #1;
        checks++;
        if ({bus.o_ready, bus.o_valid, bus.o_data} !== {1'b1, 1'b0, {OW{1'b0}}}) begin
            errors++;
            $display("FAIL rst_run_async rdy/vld/data got %b/%b/%0d want 1/0/0",
                     bus.o_ready, bus.o_valid, bus.o_data);
        end
        step();
        step();
        i_rst_an = 1'b1;
        clear_logs();
        repeat (20) begin
            step();
            checks++;
            if ({bus.o_ready, bus.o_valid, bus.o_data} !== {1'b1, 1'b0, {OW{1'b0}}}) begin
                errors++;
                $display("FAIL rst_run_quiet cyc=%0d rdy/vld/data got %b/%b/%0d want 1/0/0",
                         cyc, bus.o_ready, bus.o_valid, bus.o_data);
            end
        end
        test_impulse("impulse_after_reset");
    endtask

    task automatic test_random();
        do_reset();
        clear_logs();
        repeat (600) begin
            i_ena       = ($urandom_range(0, 99) < 85);
            bus.i_valid = ($urandom_range(0, 99) < 40);
            bus.i_data  = gp_data_width'($urandom);
            step();
            checks++;
            if ({bus.o_ready, bus.o_valid, bus.o_data} !== {~busy, exp_valid, exp_data[OW-1:0]}) begin
                errors++;
                $display("FAIL random cyc=%0d rdy/vld/data got %b/%b/%0d want %b/%b/%0d", cyc,
                         bus.o_ready, bus.o_valid, bus.o_data, ~busy, exp_valid, exp_data);
            end
        end
        i_ena       = 1'b1;
        bus.i_valid = 1'b0;
    endtask

    initial begin
        i_rst_an    = 1'b0;
        i_ena       = 1'b1;
        bus.i_valid = 1'b0;
        bus.i_data  = '0;
        model_reset();
        test_reset();
        test_impulse("impulse");
        test_dc();
        test_handshake();
        test_stall();
        test_reset_mid_run();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/filt_intp_mac.md
# filt_intp_mac

Serial-MAC polyphase interpolating FIR filter: accepts one input sample, then produces `gp_intp_factor` output samples, one per polyphase branch. All products are computed on a single shared multiplier-accumulator. It is the up-sampling counterpart of the serial MAC filter and sits on the rate-increasing side of the DSP chain, behind a ready/valid input handshake, with a strobed output.

## Interface
- `gp_data_width`, 8: input sample width, signed.
- `gp_coeff_width`, 12: coefficient width, signed.
- `gp_intp_factor`, 4: interpolation factor L, i.e. the number of polyphase branches; must be ≥2.
- `gp_phase_length`, 4: taps per branch P; must be ≥2. Total coefficients N = L·P.
- `gp_oup_width`, `gp_data_width+gp_coeff_width+$clog2(gp_phase_length)`: output width; full precision.

Ports:
- `i_clk`, in, 1: single clock, rising edge.
- `i_rst_an`, in, 1: asynchronous, active-low reset.
- `i_ena`, in, 1: clock enable. When low, every register holds.
- `i_data`, in, `gp_data_width`: input sample, signed.
- `i_valid`, in, 1: `i_data` is valid.
- `o_ready`, out, 1: block can accept an input this cycle. Reset value 1.
- `o_data`, out, `gp_oup_width`: output sample, signed, registered. Reset value 0.
- `o_valid`, out, 1: one-cycle strobe, `o_data` updated. Reset value 0.

## Operation
- Delay line: P registers `dl[0..P-1]`, reset to 0.
  - Input is accepted on an edge where `i_ena & i_valid & o_ready`.
  - On accept: `dl[0]<=i_data`, `dl[k]<=dl[k-1]`.
- FSM states:
  - IDLE: `o_ready`=1.
    - Accept → RUN, with phase counter p=0 and tap counter k=0.
  - RUN: `o_ready`=0. Each enabled cycle performs one MAC: `acc <= acc + dl[k]*c[k·L+p]`.
    - k<P-1: k increments.
    - k=P-1: `o_data <= acc + dl[k]*c[k·L+p]`, `o_valid`<=1, acc<=0, k<=0.
      - If p<L-1: p increments and the FSM stays in RUN.
      - If p=L-1: p<=0 and the FSM goes to IDLE.
  - `i_valid` is ignored while in RUN; no input is lost because `o_ready`=0.
- Output for input index n, phase p: y[nL+p] = Σ_{k=0..P-1} x[n-k]·c[kL+p].
  - Phases are emitted in order p=0..L-1.
- Arithmetic:
  - Product is `gp_data_width+gp_coeff_width` bits, signed×signed.
  - Accumulator is `gp_oup_width` bits, sign-extended. It cannot overflow for any inputs.
  - No rounding, no saturation.
- `i_ena` low: FSM, counters, delay line, acc, `o_data` and `o_valid` all hold. A held `o_valid`=1 is therefore seen again. Consumers qualify `o_valid` with `i_ena`.
- Reset asserted mid-RUN: immediately returns to IDLE.
  - acc, p, k, delay line, `o_data` and `o_valid` go to 0; `o_ready`=1.
  - The partial sum is discarded and no `o_valid` is emitted.

## Timing
- Accept edge at cycle 0; RUN occupies cycles 1..L·P.
- First `o_valid` is high in cycle P+1. Subsequent strobes are every P cycles: cycles P+1, 2P+1, …, L·P+1.
- `o_ready` rises in cycle L·P+1, the same cycle as the last `o_valid`.
  - An input presented then is accepted at that edge.
  - Sustained throughput is one input per L·P+1 enabled cycles.
- `o_valid` outside these cycles is 0 (all cycles enabled).
- `o_data` changes only on edges that set `o_valid`.

## Structure
- Package `filt_intp_pkg` holds:
  - the coefficient array `c[0..N-1]`, generated, in the same style as the serial MAC filter's coefficient include;
  - derived constants: N, counter widths `$clog2(L)` and `$clog2(P)`, product width, accumulator width.
- Sub-module `filt_intp_ctrl`: the FSM plus the p/k counters. It outputs `o_ready`, the coefficient index k·L+p, the tap index k and a last-tap flag.
- The top level holds the delay line, the MAC datapath and the output register.

## Test plan
Bench build uses L=4, P=4, c[j]=j+1 for j=0..15; all cycles enabled unless stated.

- Reset: hold `i_rst_an`=0 → `o_ready`=1, `o_valid`=0, `o_data`=0. After release with no `i_valid`, outputs stay unchanged.
- Impulse: inputs 1,0,0,0 back-to-back → 16 `o_valid` strobes carrying 1,2,…,16 in order. The first strobe is in cycle 5 after the first accept.
- DC at full scale: constant −128 for ≥4 inputs → steady phases p=0..3 give −128·{28,32,36,40} = −3584, −4096, −4608, −5120.
  - Check sign extension and no overflow.
- Handshake: `i_valid` held high continuously → accepts spaced exactly 17 cycles apart and `o_ready` low throughout RUN. A sample presented mid-RUN is held until `o_ready`, then consumed exactly once.
- Enable stall: drop `i_ena` for 3 cycles mid-RUN (phase 1, k=2) → all state frozen. The output sequence equals the unstalled run, shifted by 3 cycles.
- Reset mid-RUN: assert reset at phase 2 → no further `o_valid`. The next impulse after release reproduces 1..16 exactly, proving the delay line was cleared.
